// File: rtl/pingpong_buf_pkg.sv
// Shared types and helpers for the ping-pong window buffer.
package pingpong_buf_pkg;

  // Number of banks currently holding committed data.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_HALF  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Bank-relative address width for a given bank depth.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ppbuf_bank_ram.sv
// Simple dual-port RAM holding both banks (2*DEPTH words), one write, one synchronous read.
module ppbuf_bank_ram
  import pingpong_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [addr_w(DEPTH):0]    waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  input  logic [addr_w(DEPTH):0]    raddr,
  output logic [DATA_W-1:0]         rdata
);

  localparam int unsigned WORDS = 2 * DEPTH;

  logic [DATA_W-1:0] mem [WORDS];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read port; holds last value when idle.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pingpong_window_buf.sv
// Two-bank ping-pong feature-map buffer: one write port, NUM_RD parallel read ports.
// Optional macro PINGPONG_RD_REG_EN adds an output register stage (read latency 2).
module pingpong_window_buf
  import pingpong_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned NUM_RD = 25
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic [addr_w(DEPTH)-1:0]             wr_addr,
  input  logic [DATA_W-1:0]                    wr_data,
  input  logic                                 wr_commit,
  output logic                                 wr_ready,
  input  logic                                 rd_en,
  input  logic [NUM_RD*addr_w(DEPTH)-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0]             rd_data,
  output logic                                 rd_valid,
  output logic                                 rd_avail,
  input  logic                                 rd_release,
  output logic                                 err_ovf,
  output logic                                 err_udf
);

  localparam int unsigned AW = addr_w(DEPTH);

  occ_e occ_q, occ_d;
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  logic err_ovf_d, err_udf_d;
  logic commit_acc, rel_acc;
  logic wr_fire, rd_issue;
  logic rd_vld1;
  logic [DATA_W-1:0]        ram_q [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] gated_data;

  assign wr_ready = (occ_q != OCC_FULL);
  assign rd_avail = (occ_q != OCC_EMPTY);
  assign wr_fire  = wr_en & wr_ready;
  assign rd_issue = rd_en & rd_avail;

  // State register: occupancy, bank pointers and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= OCC_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      err_ovf   <= err_ovf_d;
      err_udf   <= err_udf_d;
    end
  end

  // Next-state: a release in the same cycle frees a bank, so a commit at FULL still lands.
  always_comb begin
    occ_d      = occ_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    err_ovf_d  = err_ovf;
    err_udf_d  = err_udf;
    rel_acc    = rd_release & rd_avail;
    commit_acc = wr_commit & (wr_ready | rel_acc);

    if (commit_acc) wr_bank_d = ~wr_bank_q;
    if (rel_acc)    rd_bank_d = ~rd_bank_q;

    case (occ_q)
      OCC_EMPTY: if (commit_acc) occ_d = OCC_HALF;
      OCC_HALF: begin
        if (commit_acc && !rel_acc)      occ_d = OCC_FULL;
        else if (rel_acc && !commit_acc) occ_d = OCC_EMPTY;
      end
      OCC_FULL:  if (rel_acc && !commit_acc) occ_d = OCC_HALF;
      default:   occ_d = OCC_EMPTY;
    endcase

    if ((wr_en && !wr_ready) || (wr_commit && !commit_acc)) err_ovf_d = 1'b1;
    if (rd_release && !rd_avail)                            err_udf_d = 1'b1;
  end

  // First read-valid stage; bank is captured at issue inside the RAM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld1 <= 1'b0;
    else        rd_vld1 <= rd_issue;
  end

  // One RAM copy per read port; writes broadcast to all copies.
  for (genvar j = 0; j < NUM_RD; j++) begin : g_port
    ppbuf_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk   (clk),
      .we    (wr_fire),
      .waddr ({wr_bank_q, wr_addr}),
      .wdata (wr_data),
      .re    (rd_issue),
      .raddr ({rd_bank_q, rd_addr[AW*j +: AW]}),
      .rdata (ram_q[j])
    );
    assign gated_data[DATA_W*j +: DATA_W] = ram_q[j] & {DATA_W{rd_vld1}};
  end

`ifdef PINGPONG_RD_REG_EN
  // Extra output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_vld1;
      rd_data  <= gated_data;
    end
  end
`else
  assign rd_valid = rd_vld1;
  assign rd_data  = gated_data;
`endif

endmodule

// File: tb/tb_pingpong_window_buf.sv
// Self-checking bench for pingpong_window_buf (scoreboard of expected read vectors).
module tb_pingpong_window_buf;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NR    = 25;
  localparam int unsigned AW    = 10;
`ifdef PINGPONG_RD_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_commit;
  logic              wr_ready;
  logic              rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_avail;
  logic              rd_release;
  logic              err_ovf;
  logic              err_udf;

  int n_cmp = 0;
  int n_err = 0;
  logic [NR*DW-1:0] exp_q [$];
  logic [1:0]       vpipe = 2'b00;

  pingpong_window_buf #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_avail   (rd_avail),
    .rd_release (rd_release),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf)
  );

  always #5 clk = ~clk;

  function automatic logic [NR*DW-1:0] rep8(input logic [DW-1:0] b);
    logic [NR*DW-1:0] v;
    for (int j = 0; j < int'(NR); j++) v[j*DW +: DW] = b;
    return v;
  endfunction

  function automatic logic [NR*AW-1:0] addr_pat(input int stride, input int base);
    logic [NR*AW-1:0] v;
    for (int j = 0; j < int'(NR); j++) v[j*AW +: AW] = AW'((base + j*stride) % int'(DEPTH));
    return v;
  endfunction

  // Data written as address[7:0], so expected data follows the address pattern.
  function automatic logic [NR*DW-1:0] data_pat(input int stride, input int base);
    logic [NR*DW-1:0] v;
    for (int j = 0; j < int'(NR); j++) v[j*DW +: DW] = DW'(((base + j*stride) % int'(DEPTH)) & 255);
    return v;
  endfunction

  // One cycle: score read outputs, record expectation, then drive new inputs.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic wc, input logic re, input logic rr,
                      input logic [NR*AW-1:0] ra, input logic ev, input logic [NR*DW-1:0] ed);
    logic [NR*DW-1:0] e;
    @(negedge clk);
    n_cmp++;
    if (rd_valid !== vpipe[LAT-1]) begin
      n_err++;
      $display("FAIL rd_valid_timing: got %b expected %b at %0t", rd_valid, vpipe[LAT-1], $time);
    end
    if (vpipe[LAT-1]) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_data !== e) begin
        n_err++;
        $display("FAIL rd_data: got %h expected %h at %0t", rd_data, e, $time);
      end
    end else begin
      n_cmp++;
      if (rd_data !== '0) begin
        n_err++;
        $display("FAIL rd_data_gated: got %h expected 0 at %0t", rd_data, $time);
      end
    end
    vpipe = {vpipe[0], ev};
    if (ev) exp_q.push_back(ed);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_commit = wc;
    rd_en = re; rd_release = rr; rd_addr = ra;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic c);
    step(1'b1, AW'(a), d, c, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [NR*AW-1:0] ra, input logic [NR*DW-1:0] ed);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, ra, 1'b1, ed);
  endtask

  task automatic drain();
    for (int i = 0; i < int'(LAT) + 1; i++) idle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_commit = 0;
    rd_en = 0; rd_release = 0; rd_addr = '0;
    exp_q.delete();
    vpipe = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    n_cmp++; if (rd_avail !== 1'b0) begin n_err++; $display("FAIL reset_rd_avail: got %b expected 0", rd_avail); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    n_cmp++; if ({err_ovf, err_udf} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b expected 00", {err_ovf, err_udf}); end
  endtask

  task automatic test_basic_fill();
    for (int k = 0; k < int'(DEPTH); k++) wr(k, DW'(k & 255), 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idle();
    n_cmp++; if (rd_avail !== 1'b1) begin n_err++; $display("FAIL fill_rd_avail: got %b expected 1", rd_avail); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fill_wr_ready: got %b expected 1", wr_ready); end
    rd(addr_pat(40, 0), data_pat(40, 0));
    rd(addr_pat(41, 7), data_pat(41, 7));
    rd(addr_pat(1, 1000), data_pat(1, 1000));
    drain();
  endtask

  task automatic test_pingpong();
    apply_reset();
    for (int k = 0; k < int'(DEPTH); k++) wr(k, 8'hA5, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < int'(DEPTH); k++)
      step(1'b1, AW'(k), 8'h5A, 1'b0, 1'b1, 1'b0, addr_pat(1, k), 1'b1, rep8(8'hA5));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    idle();
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL pp_full_wr_ready: got %b expected 0", wr_ready); end
    n_cmp++; if (rd_avail !== 1'b1) begin n_err++; $display("FAIL pp_full_rd_avail: got %b expected 1", rd_avail); end
    rd(addr_pat(3, 11), rep8(8'hA5));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
    idle();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL pp_release_wr_ready: got %b expected 1", wr_ready); end
    rd(addr_pat(40, 5), rep8(8'h5A));
    rd(addr_pat(7, 900), rep8(8'h5A));
    drain();
  endtask

  task automatic test_overflow();
    // Entry: HALF, reader on bank1 (5A), writer on bank0.
    wr(0, 8'h11, 1'b1);
    idle();
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL ovf_full: got %b expected 0", wr_ready); end
    n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b expected 0", err_ovf); end
    wr(0, 8'hEE, 1'b1);
    idle();
    n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", err_ovf); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL ovf_still_full: got %b expected 0", wr_ready); end
    rd(addr_pat(0, 0), rep8(8'h5A));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0, 1'b0, '0);
    idle();
    n_cmp++; if ({wr_ready, rd_avail} !== 2'b01) begin n_err++; $display("FAIL ovf_swap_full: got %b expected 01", {wr_ready, rd_avail}); end
    rd(addr_pat(0, 0), rep8(8'h11));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
    idle();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL ovf_release_ready: got %b expected 1", wr_ready); end
    n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", err_ovf); end
    rd(addr_pat(0, 0), rep8(8'h5A));
    drain();
  endtask

  task automatic test_underflow();
    apply_reset();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
    idle();
    n_cmp++; if (err_udf !== 1'b1) begin n_err++; $display("FAIL udf_set: got %b expected 1", err_udf); end
    n_cmp++; if (rd_avail !== 1'b0) begin n_err++; $display("FAIL udf_empty: got %b expected 0", rd_avail); end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, addr_pat(1, 0), 1'b0, '0);
    idle();
    n_cmp++; if ({rd_valid, rd_data} !== '0) begin n_err++; $display("FAIL udf_empty_read: got %b/%h expected 0/0", rd_valid, rd_data); end
    // Commit and release together at EMPTY: commit taken, release rejected.
    step(1'b1, '0, 8'h33, 1'b1, 1'b0, 1'b1, '0, 1'b0, '0);
    idle();
    n_cmp++; if (rd_avail !== 1'b1) begin n_err++; $display("FAIL udf_commit_taken: got %b expected 1", rd_avail); end
    n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL udf_no_ovf: got %b expected 0", err_ovf); end
    rd(addr_pat(0, 0), rep8(8'h33));
    drain();
  endtask

  task automatic test_read_release_and_reset();
    // Entry: HALF, reader on bank0 (33 at addr 0), writer on bank1.
    wr(0, 8'h44, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, addr_pat(0, 0), 1'b1, rep8(8'h33));
    idle();
    n_cmp++; if (rd_avail !== 1'b0) begin n_err++; $display("FAIL rr_empty: got %b expected 0", rd_avail); end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    rd(addr_pat(0, 0), rep8(8'h44));
    wr(1, 8'h55, 1'b0);
    wr(2, 8'h66, 1'b0);
    rd(addr_pat(0, 0), rep8(8'h44));
    rd(addr_pat(0, 0), rep8(8'h44));
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({wr_ready, rd_avail, rd_valid} !== 3'b100) begin n_err++; $display("FAIL midreset_flags: got %b expected 100", {wr_ready, rd_avail, rd_valid}); end
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL midreset_rd_data: got %h expected 0", rd_data); end
    exp_q.delete();
    vpipe = 2'b00;
    wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_commit = 0;
    rd_en = 0; rd_release = 0; rd_addr = '0;
    test_reset();
    test_basic_fill();
    test_pingpong();
    test_overflow();
    test_underflow();
    test_read_release_and_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
